apu_i2s: RTL and testbench

APU_I2S -- requirements
Module: apu_i2s

---
 rtl/apu_i2s.sv | 118 +++++++++++
 tb/tb_apu_i2s.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_i2s.sv
// APU mixer sample to I2S serializer, mono source duplicated to both channels.
// Define APU_I2S_AVG_EN to box-average each frame window instead of point sampling.
module apu_i2s #(
  parameter int BCLK_DIV = 8
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       en,
  input  logic [7:0] in,
  output logic       bclk,
  output logic       lrclk,
  output logic       sdata,
  output logic       sample_stb
);

  localparam int DW = $clog2(BCLK_DIV);
  localparam int SH = $clog2(64 * BCLK_DIV);
  localparam int AW = 8 + SH;

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic [4:0]    slot_q, slot_d;
  logic          lrclk_q, lrclk_d;
  logic          stb_q, stb_d;
  logic [31:0]   sr_q, sr_d;

  logic          tick;
  logic          fall;
  logic          load;
  logic [4:0]    slot_inc;
  logic [7:0]    s_c;
  logic [15:0]   word_c;

  assign tick     = en && (div_q == DW'(BCLK_DIV - 1));
  assign fall     = tick && bclk_q;
  assign load     = fall && (slot_q == 5'd0);
  assign slot_inc = slot_q + 5'd1;

`ifdef APU_I2S_AVG_EN
  logic [AW-1:0] acc_q, acc_d;

  // Window restarts with the load clk's own sample.
  always_comb begin
    acc_d = acc_q + AW'(in);
    if (!en) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = AW'(in);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign s_c = acc_q[AW-1 -: 8];
`else
  assign s_c = in;
`endif

  assign word_c = {s_c - 8'h80, 8'h00};

  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    slot_d  = slot_q;
    lrclk_d = lrclk_q;
    stb_d   = 1'b0;
    sr_d    = sr_q;
    if (!en) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      slot_d  = 5'd0;
      lrclk_d = 1'b0;
      sr_d    = '0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) begin
        bclk_d = ~bclk_q;
      end
      if (fall) begin
        slot_d  = slot_inc;
        lrclk_d = slot_inc[4];
        sr_d    = load ? {word_c, word_c}
                       : {sr_q[30:0], 1'b0};
      end
      stb_d = load;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      slot_q  <= 5'd0;
      lrclk_q <= 1'b0;
      stb_q   <= 1'b0;
      sr_q    <= '0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      slot_q  <= slot_d;
      lrclk_q <= lrclk_d;
      stb_q   <= stb_d;
      sr_q    <= sr_d;
    end
  end

  assign bclk       = bclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sr_q[31];
  assign sample_stb = stb_q;

endmodule

// File: tb/tb_apu_i2s.sv
// Directed bench for apu_i2s: reset, conversion table, timing,
// averaging window and mid-frame disable.
module tb_apu_i2s;

  localparam int DIV = 8;

  logic       clk;
  logic       n_reset;
  logic       en;
  logic [7:0] in;
  logic       bclk;
  logic       lrclk;
  logic       sdata;
  logic       sample_stb;

  int checks;
  int errors;

  apu_i2s #(.BCLK_DIV(DIV)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .en         (en),
    .in         (in),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .sample_stb (sample_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  in;
    logic [15:0] w;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_stb && n < 2000);
    if (!sample_stb) check("stb_timeout", 32'd0, 32'd1);
  endtask

  // Receiver view: sample sdata and lrclk on bclk rise for one frame.
  task automatic capture(output logic [15:0] l, output logic [15:0] r,
                         output int lr_err);
    logic [31:0] w;
    logic        pb;
    logic        lr_exp;
    int          i;
    int          t;
    w = '0;
    i = 0;
    t = 0;
    lr_err = 0;
    pb = bclk;
    while (i < 32 && t < 2000) begin
      step();
      t++;
      if (!pb && bclk) begin
        w = {w[30:0], sdata};
        lr_exp = (i >= 15 && i <= 30);
        if (lrclk !== lr_exp) lr_err++;
        i++;
      end
      pb = bclk;
    end
    if (i < 32) check("capture_timeout", 32'(i), 32'd32);
    l = w[31:16];
    r = w[15:0];
  endtask

  initial begin
    int          n;
    int          bad;
    int          lr_err;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] avg_exp;
    logic        pb;
    logic        plr;
    logic        pstb;
    int          t_b0, t_b1, t_l0, t_l1, t_s0, t_s1;
    int          lr_bad, stb_wide;

    checks = 0;
    errors = 0;
    vt[0] = '{8'hFF, 16'h7F00};
    vt[1] = '{8'h80, 16'h0000};
    vt[2] = '{8'h00, 16'h8000};
    vt[3] = '{8'hC0, 16'h4000};
    vt[4] = '{8'h7F, 16'hFF00};
    vt[5] = '{8'h01, 16'h8100};

    n_reset = 1'b0;
    en      = 1'b1;
    in      = 8'hFF;

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({bclk, lrclk, sdata, sample_stb} != 4'b0) bad++;
    end
    check("reset_outputs", 32'(bad), 32'd0);

    n_reset = 1'b1;
    n = 0;
    bad = 0;
    do begin
      step();
      n++;
      if (sdata) bad++;
    end while (!bclk && n < 100);
    check("reset_first_bclk", 32'(n), 32'(DIV));
    while (!sample_stb && n < 200) begin
      step();
      n++;
      if (sdata) bad++;
    end
    check("reset_first_stb", 32'(n), 32'(2 * DIV));
    check("reset_sdata_preload", 32'(bad), 32'd0);

    foreach (vt[k]) begin
      in = vt[k].in;
      wait_stb(n);
      wait_stb(n);
      capture(l, r, lr_err);
      check($sformatf("left_%0h", vt[k].in), 32'(l), 32'(vt[k].w));
      check($sformatf("right_%0h", vt[k].in), 32'(r), 32'(vt[k].w));
      check($sformatf("lrclk_%0h", vt[k].in), 32'(lr_err), 32'd0);
    end

    wait_stb(n);
    pb = bclk;
    plr = lrclk;
    pstb = sample_stb;
    t_b0 = 0; t_b1 = 0; t_l0 = 0; t_l1 = 0; t_s0 = 0; t_s1 = 0;
    lr_bad = 0;
    stb_wide = 0;
    for (int c = 1; c <= 1200; c++) begin
      step();
      if (!pb && bclk) begin t_b0 = t_b1; t_b1 = c; end
      if (!plr && lrclk) begin t_l0 = t_l1; t_l1 = c; end
      if (plr != lrclk && !(pb && !bclk)) lr_bad++;
      if (sample_stb) begin t_s0 = t_s1; t_s1 = c; end
      if (pstb && sample_stb) stb_wide++;
      pb = bclk;
      plr = lrclk;
      pstb = sample_stb;
    end
    check("bclk_period", 32'(t_b1 - t_b0), 32'(2 * DIV));
    check("lrclk_period", 32'(t_l1 - t_l0), 32'(64 * DIV));
    check("stb_period", 32'(t_s1 - t_s0), 32'(64 * DIV));
    check("lrclk_on_bclk_fall", 32'(lr_bad), 32'd0);
    check("stb_width", 32'(stb_wide), 32'd0);

`ifdef APU_I2S_AVG_EN
    avg_exp = 16'hFF00;
`else
    avg_exp = 16'h7F00;
`endif
    in = 8'h00;
    wait_stb(n);
    wait_stb(n);
    for (int c = 0; c < 255; c++) step();
    in = 8'hFF;
    wait_stb(n);
    check("avg_window_len", 32'(n), 32'd257);
    capture(l, r, lr_err);
    check("avg_left", 32'(l), 32'(avg_exp));
    check("avg_right", 32'(r), 32'(avg_exp));

    in = 8'hFF;
    wait_stb(n);
    n = 0;
    pb = bclk;
    while (n < 6) begin
      step();
      if (pb && !bclk) n++;
      pb = bclk;
    end
    step();
    step();
    en = 1'b0;
    step();
    check("drop_outputs", 32'({bclk, lrclk, sdata, sample_stb}), 32'd0);
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if ({bclk, lrclk, sdata, sample_stb} != 4'b0) bad++;
    end
    check("drop_idle", 32'(bad), 32'd0);

    in = 8'h80;
    en = 1'b1;
    n = 0;
    bad = 0;
    do begin
      step();
      n++;
      if (sdata || lrclk) bad++;
    end while (!bclk && n < 100);
    check("restart_first_bclk", 32'(n), 32'(DIV));
    while (!sample_stb && n < 200) begin
      step();
      n++;
      if (sdata || lrclk) bad++;
    end
    check("restart_first_stb", 32'(n), 32'(2 * DIV));
    check("restart_slot0_quiet", 32'(bad), 32'd0);
    wait_stb(n);
    check("restart_stb_period", 32'(n), 32'(64 * DIV));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
